// File: rtl/sat_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
// Direction and mode encodings match the dir/wrap port levels.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b1;
   localparam logic MODE_SAT  = 1'b0;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sat_counter_if.sv
// Control/status bundle of sat_counter; the counter is the slave side.
interface sat_counter_if #(
   parameter int unsigned WIDTH = 5
);
   logic             en;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             dir;
   logic             wrap;
   logic             ovf_clr;
   logic [WIDTH-1:0] out;
   logic             at_max;
   logic             at_zero;
   logic             tc;
   logic             ovf;

   modport master (
      output en, clear, load, load_val, dir, wrap, ovf_clr,
      input  out, at_max, at_zero, tc, ovf
   );

   modport slave (
      input  en, clear, load, load_val, dir, wrap, ovf_clr,
      output out, at_max, at_zero, tc, ovf
   );
endinterface

// File: rtl/sat_counter_tick_gen.sv
// Prescaler: one tick every PRESCALE enabled cycles; restart/reset return it to phase 0.
// With PRESCALE=1 the tick is simply the enable.
module tick_gen
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   if (PRESCALE == 1) begin : g_pass
      logic unused_inputs;
      assign unused_inputs = ^{clock, reset, restart};
      assign tick          = en;
   end else begin : g_div
      localparam int unsigned PW = cnt_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] p_q, p_d;

      assign tick = en && (p_q == LAST);

      always_comb begin
         p_d = p_q;
         if (restart)    p_d = '0;
         else if (tick)  p_d = '0;
         else if (en)    p_d = p_q + PW'(1);
      end

      always_ff @(posedge clock) begin
         if (reset) p_q <= '0;
         else       p_q <= p_d;
      end
   end

endmodule

// File: rtl/sat_counter.sv
// Up/down counter with wrap/saturate bounds, clamped parallel load, prescaler,
// one-cycle carry/borrow pulse and sticky overflow flag.
module sat_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic         clock,
   input  logic         reset,
   sat_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             tick;
   logic             restart;
   logic             hit;

   assign restart = bus.clear | bus.load;

   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clock  (clock),
      .reset  (reset),
      .en     (bus.en),
      .restart(restart),
      .tick   (tick)
   );

   // ovf_clr is applied first so a bound hit in the same cycle overrides it.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      hit   = 1'b0;
      if (bus.ovf_clr) ovf_d = 1'b0;
      if (bus.clear) begin
         cnt_d = '0;
      end else if (bus.load) begin
         cnt_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      end else if (tick) begin
         hit = (bus.dir == DIR_UP) ? (cnt_q == MAX_V) : (cnt_q == '0);
         if (!hit)
            cnt_d = (bus.dir == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
         else if (bus.wrap == MODE_WRAP)
            cnt_d = (bus.dir == DIR_UP) ? '0 : MAX_V;
         tc_d = hit;
         if (hit) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.out     = cnt_q;
   assign bus.at_max  = (cnt_q == MAX_V);
   assign bus.at_zero = (cnt_q == '0);
   assign bus.tc      = tc_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sat_counter.sv
// Bench for sat_counter: two configurations share one stimulus stream and are
// checked every cycle against an integer model, plus directed literal checks.
module tb_sat_counter;

   logic       clk = 1'b0;
   logic       rst, en, clr, ld, dir, wrap, oclr;
   logic [4:0] lv;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sat_counter_if #(.WIDTH(5)) bus_a ();
   sat_counter_if #(.WIDTH(5)) bus_b ();

   assign bus_a.en = en;   assign bus_b.en = en;
   assign bus_a.clear = clr;  assign bus_b.clear = clr;
   assign bus_a.load = ld;    assign bus_b.load = ld;
   assign bus_a.load_val = lv; assign bus_b.load_val = lv;
   assign bus_a.dir = dir;    assign bus_b.dir = dir;
   assign bus_a.wrap = wrap;  assign bus_b.wrap = wrap;
   assign bus_a.ovf_clr = oclr; assign bus_b.ovf_clr = oclr;

   sat_counter #(.WIDTH(5), .MAX_COUNT(31), .PRESCALE(1)) dut_a (
      .clock(clk), .reset(rst), .bus(bus_a));
   sat_counter #(.WIDTH(5), .MAX_COUNT(9), .PRESCALE(4)) dut_b (
      .clock(clk), .reset(rst), .bus(bus_b));

   typedef struct {
      int out;
      int p;
      bit tc;
      bit ovf;
   } mst_t;

   mst_t ma, mb;
   bit   mvalid = 0;

   function automatic mst_t mstep(mst_t s, int maxc, int pre);
      mst_t n = s;
      bit   tk, hitb;
      n.tc = 0;
      if (rst) begin
         n.out = 0; n.p = 0; n.ovf = 0;
      end else if (clr || ld) begin
         n.out = clr ? 0 : ((int'(lv) > maxc) ? maxc : int'(lv));
         n.p   = 0;
         if (oclr) n.ovf = 0;
      end else begin
         tk = en && (s.p == pre - 1);
         if (en) n.p = tk ? 0 : s.p + 1;
         hitb = 0;
         if (tk) begin
            hitb = dir ? (s.out == maxc) : (s.out == 0);
            if (!hitb)     n.out = dir ? s.out + 1 : s.out - 1;
            else if (wrap) n.out = dir ? 0 : maxc;
            n.tc = hitb;
         end
         if (hitb)      n.ovf = 1;
         else if (oclr) n.ovf = 0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma = mstep(ma, 31, 1);
      mb = mstep(mb, 9, 4);
      if (rst) mvalid = 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         check("a.out", int'(bus_a.out), ma.out);
         check("a.at_max", int'(bus_a.at_max), int'(ma.out == 31));
         check("a.at_zero", int'(bus_a.at_zero), int'(ma.out == 0));
         check("a.tc", int'(bus_a.tc), int'(ma.tc));
         check("a.ovf", int'(bus_a.ovf), int'(ma.ovf));
         check("b.out", int'(bus_b.out), mb.out);
         check("b.at_max", int'(bus_b.at_max), int'(mb.out == 9));
         check("b.at_zero", int'(bus_b.at_zero), int'(mb.out == 0));
         check("b.tc", int'(bus_b.tc), int'(mb.tc));
         check("b.ovf", int'(bus_b.ovf), int'(mb.ovf));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; en = 0; clr = 0; ld = 0; lv = '0; dir = 1; wrap = 0; oclr = 0;
      cycle();
      check("lit reset a.out", int'(bus_a.out), 0);
      check("lit reset a.ovf", int'(bus_a.ovf), 0);
      check("lit reset b.tc", int'(bus_b.tc), 0);
      rst = 0; en = 1;

      // Saturating count up from reset
      repeat (31) cycle();
      check("lit sat a.out31", int'(bus_a.out), 31);
      check("lit sat a.tc0", int'(bus_a.tc), 0);
      check("lit sat a.ovf0", int'(bus_a.ovf), 0);
      check("lit pre b.out7", int'(bus_b.out), 7);
      cycle();
      check("lit sat a.tc32", int'(bus_a.tc), 1);
      check("lit sat a.ovf32", int'(bus_a.ovf), 1);
      check("lit sat a.hold", int'(bus_a.out), 31);
      cycle();
      check("lit sat a.tc33", int'(bus_a.tc), 1);

      // Wrap up then down
      wrap = 1;
      cycle();
      check("lit wrap a.out0", int'(bus_a.out), 0);
      check("lit wrap a.tc", int'(bus_a.tc), 1);
      check("lit wrap a.at_zero", int'(bus_a.at_zero), 1);
      dir = 0;
      cycle();
      check("lit wrapdn a.out31", int'(bus_a.out), 31);
      check("lit wrapdn a.tc", int'(bus_a.tc), 1);

      // Clamped load, then saturated tick
      dir = 1; wrap = 0; ld = 1; lv = 5'd20;
      cycle();
      ld = 0;
      check("lit load b.out9", int'(bus_b.out), 9);
      check("lit load b.at_max", int'(bus_b.at_max), 1);
      check("lit load b.tc0", int'(bus_b.tc), 0);
      check("lit load a.out20", int'(bus_a.out), 20);
      check("lit load b.ovf0", int'(bus_b.ovf), 0);
      repeat (3) cycle();
      check("lit presc b.tc0", int'(bus_b.tc), 0);
      cycle();
      check("lit satb b.tc", int'(bus_b.tc), 1);
      check("lit satb b.ovf", int'(bus_b.ovf), 1);
      check("lit satb b.out9", int'(bus_b.out), 9);

      // ovf_clr alone, then coincident with a bound hit
      oclr = 1;
      cycle();
      check("lit oclr b.ovf0", int'(bus_b.ovf), 0);
      repeat (3) cycle();
      check("lit oclr+hit b.ovf1", int'(bus_b.ovf), 1);
      oclr = 0;
      clr = 1;
      cycle();
      clr = 0;
      check("lit clear b.out0", int'(bus_b.out), 0);
      check("lit clear b.ovf kept", int'(bus_b.ovf), 1);

      // Reset with load and tick due
      repeat (7) cycle();
      check("lit mid b.out1", int'(bus_b.out), 1);
      rst = 1; ld = 1; lv = 5'd5;
      cycle();
      rst = 0; ld = 0;
      check("lit rst b.out0", int'(bus_b.out), 0);
      check("lit rst b.ovf0", int'(bus_b.ovf), 0);
      check("lit rst a.out0", int'(bus_a.out), 0);
      repeat (3) cycle();
      check("lit rst b.nostep", int'(bus_b.out), 0);
      cycle();
      check("lit rst b.step", int'(bus_b.out), 1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) dir  = ~dir;
         if ($urandom_range(31) == 0) wrap = ~wrap;
         ld   = ($urandom_range(39) == 0);
         lv   = 5'($urandom);
         clr  = ($urandom_range(59) == 0);
         oclr = ($urandom_range(19) == 0);
         rst  = ($urandom_range(299) == 0);
         cycle();
      end
      rst = 0; ld = 0; clr = 0; oclr = 0;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sat_counter.md
# sat_counter

Parametrised up/down counter that succeeds the fixed 5-bit saturating counter used for step timing and PWM sequencing. It adds configurable width and terminal value, per-cycle direction, wrap or saturate mode, parallel load, a clock prescaler, a carry pulse for cascading, and a sticky overflow flag. It is a leaf block instantiated by the motor-step and servo-timing controllers.

## Interface
Parameters:
- WIDTH, 5, counter width in bits (2..16)
- MAX_COUNT, 2**WIDTH-1, terminal (upper) value; must be ≥1 and ≤2**WIDTH-1
- PRESCALE, 1, enabled cycles per count step (1..256); 1 = step every enabled cycle

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; highest priority
- en  in  1  count enable; gates prescaler and stepping
- clear  in  1  synchronous clear of count and prescaler
- load  in  1  parallel load strobe
- load_val  in  WIDTH  load value; values >MAX_COUNT clamp to MAX_COUNT
- dir  in  1  1 = up, 0 = down; sampled on each step
- wrap  in  1  1 = wrap at bound, 0 = saturate at bound
- ovf_clr  in  1  clears sticky ovf
- out  out  WIDTH  current count (registered)
- at_max  out  1  combinational, out == MAX_COUNT
- at_zero  out  1  combinational, out == 0
- tc  out  1  registered one-cycle carry/borrow pulse
- ovf  out  1  registered sticky overflow/underflow flag

## Operation
- Per-edge priority: reset > clear > load > step > hold.
- reset: out=0, prescaler=0, tc=0, ovf=0.
- clear: out=0, prescaler=0, tc=0; ovf unchanged.
- load: out=min(load_val, MAX_COUNT), prescaler=0, tc=0; no step that cycle even if a tick was due.
- Prescaler: internal count p in 0..PRESCALE-1 advances only when en=1; tick = en && p==PRESCALE-1; on tick p returns to 0. With en=0, p holds.
- Step (on tick): a bound hit means dir=1 with out==MAX_COUNT, or dir=0 with out==0.
  - No bound hit: out = out±1.
  - Bound hit, wrap=1: out wraps (MAX_COUNT→0 up, 0→MAX_COUNT down).
  - Bound hit, wrap=0: out holds.
  - Every bound hit sets tc=1 for the following cycle and sets ovf.
- tc is 0 in every cycle not following a bound-hit step. Repeated saturated steps pulse tc on each tick.
- ovf: set by a bound hit, cleared by ovf_clr; if both occur in the same cycle, set wins. Only reset, not clear, also clears it.
- dir and wrap may change on any cycle; they take effect on the next tick.
- Arithmetic is WIDTH-bit unsigned. Wrap is to MAX_COUNT/0, never to 2**WIDTH-1 unless equal.

## Timing
- out, tc, ovf change only at the rising clock edge. Latency is one cycle from the tick or control cycle.
- at_max/at_zero follow out with zero latency and are valid in the cycle tc is high.
- With PRESCALE=N and en held high, out steps once every N cycles. The first step occurs N cycles after reset, clear, or load deasserts.
- Reset mid-count takes effect at the next edge, regardless of en, load, or tick.
- All outputs are deterministic the cycle after reset. No async paths.

## Structure
- Package counter_pkg holds:
  - DIR_UP=1'b1, DIR_DOWN=1'b0
  - MODE_WRAP=1'b1, MODE_SAT=1'b0
  - a clog2-based width function for the prescaler
- Sub-module tick_gen(clock, reset, en, restart, tick), parameter PRESCALE. It is pure pass-through (tick=en) when PRESCALE=1.
- Top holds the count register, bound-hit logic, tc and ovf registers.

## Test plan
- WIDTH=5, PRESCALE=1, dir=1, wrap=0, en=1 from reset for 33 cycles -> out counts 0..31 then holds at 31. tc pulses on cycle 32 and again on 33. ovf=1 from cycle 32.
- Same setup with wrap=1 -> out goes 31→0. tc is high with out=0. dir=0 at out=0 -> out=31, tc pulse.
- MAX_COUNT=9, load_val=20 with load=1 -> out=9, at_max=1, no tc. Next tick up with wrap=0 -> out stays 9, tc=1, ovf=1.
- PRESCALE=4, en=1 -> out increments on cycles 4, 8, 12. Drop en at cycle 6 for 3 cycles -> next step is at cycle 11.
- ovf_clr and a bound hit in the same cycle -> ovf stays 1. ovf_clr alone -> ovf=0 next cycle. clear leaves ovf unchanged.
- reset asserted mid-count with load=1 and a tick due -> out=0, tc=0, ovf=0 next cycle. Prescaler restarts, so the first step comes PRESCALE cycles after reset deasserts.
